saturn_bus_controller: RTL and testbench
========================================

Name: saturn_bus_controller

Overview:
- Bus master sitting between the CPU fetch/data unit and the nibble-serial Saturn bus slaves (ROM, RAM, I/O).
- Turns CPU read requests (address + nibble count) into bus command/address/data strobe sequences and returns the fetched nibbles.
- Keeps shadow copies of the slaves' PC and DP pointers so that sequential reads skip redundant LOAD_PC/LOAD_DP sequences.

Parameters:
- BUS_DIV, 4, i_clk cycles per bus slot (>=2); one strobe per slot.
- MAX_CNT_BITS, 4, width of the nibble-count field; a burst is 1..2**MAX_CNT_BITS nibbles.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_req_valid  in  1  CPU request strobe
- i_req_is_dp  in  1  0 = PC stream, 1 = DP stream
- i_req_addr  in  20  start nibble address
- i_req_cnt  in  MAX_CNT_BITS  nibble count minus one
- o_req_ready  out  1  controller idle; request accepted when valid&&ready
- o_rd_valid  out  1  one-cycle pulse, o_rd_nibble valid
- o_rd_nibble  out  4  returned nibble
- o_rd_last  out  1  set with the last o_rd_valid of a burst
- o_bus_clk_en  out  1  one-cycle bus strobe
- o_bus_is_data  out  1  0 = command nibble, 1 = data/address nibble
- o_bus_nibble_out  out  4  command/address nibble to slaves
- i_bus_nibble_in  in  4  read nibble from slaves
- o_phase_0  out  1  high during the first i_clk of each slot (slave pre-read)

Behaviour:
- Reset (async, active-low): state IDLE, slot counter 0, o_req_ready=1, o_rd_valid=0, o_rd_last=0, o_rd_nibble=0, o_bus_clk_en=0, o_bus_is_data=0, o_bus_nibble_out=0, shadow_pc=shadow_dp=0, shadow_valid=0, last_cmd=RESET code.
- Slot counter runs 0..BUS_DIV-1 continuously; o_phase_0 = (ctr==0); o_bus_clk_en pulses at ctr==BUS_DIV-1 only in CMD/ADDR/READ states.
- Acceptance in IDLE latches is_dp, addr, cnt; o_req_ready drops the next cycle. Next state:
  - hit (shadow_valid and addr == shadow of that stream) and last_cmd == matching READ code -> READ;
  - hit but last_cmd differs -> CMD with DP_READ/PC_READ code, then READ;
  - miss -> CMD with LOAD_DP/LOAD_PC, then ADDR.
- CMD: one strobe, is_data=0, nibble = command code; last_cmd updated.
- ADDR: five strobes, is_data=1, address nibbles LSB first (addr[3:0] first); slave auto-switches to the read command after the 5th; last_cmd := matching READ code, shadow := addr, shadow_valid := 1.
- READ: cnt+1 strobes, is_data=1, nibble_out=0. i_bus_nibble_in sampled the i_clk after each strobe -> o_rd_valid pulse (slave registers data on the strobe edge). Shadow of the stream increments per strobe, 20-bit wrap FFFFF -> 00000. o_rd_last on final nibble; then IDLE, o_req_ready=1 the following cycle.
- Command codes come only from the shared bus-command definitions.
- Request fields ignored while not ready; no queueing.
- Reset mid-burst aborts immediately; no further o_rd_valid; shadow_valid=0 forces LOAD on next request.
- Latency (miss, cnt=0, BUS_DIV=4, accepted with ctr==0): first o_rd_valid 7 slots later +1 cycle.

Decomposition:
- Command codes already in the shared bus-command include; add FSM state encoding and the 5-nibble address length there.
- One sub-module: saturn_bus_slot_timer (slot counter, o_phase_0, strobe enable).

Test Plan:
- Miss read: PC addr=0x12345, cnt=0 -> strobes CMD LOAD_PC, data 5,4,3,2,1, one read strobe; one o_rd_valid with o_rd_last=1 equal to slave nibble at 0x12345.
- Sequential hit: then PC addr=0x12346, cnt=3 -> no CMD/ADDR strobes, 4 read strobes, 4 nibbles from 0x12346..0x12349, o_rd_last on 4th only.
- Stream switch: DP load to 0x00010 (cnt=0), then PC read at shadow 0x1234A -> single PC_READ command strobe, then reads.
- Wrap: PC addr=0xFFFFF, cnt=1 -> nibbles from 0xFFFFF and 0x00000; next request at 0x00001 is a hit.
- Reset mid-READ of cnt=15 after 3 nibbles -> outputs at reset values asynchronously; next PC request to 0x12348 issues LOAD_PC.
- Request while busy: i_req_valid held during burst -> ignored until o_req_ready=1, then accepted exactly once.

Source files
------------

// File: rtl/saturn_bus_controller_pkg.sv
// saturn_bus_controller_pkg: shared bus-command codes, controller state encoding and address length
package saturn_bus_controller_pkg;

    typedef enum logic [3:0] {
        CMD_PC_READ     = 4'h0,
        CMD_DP_READ     = 4'h1,
        CMD_DP_WRITE    = 4'h2,
        CMD_READ_ID     = 4'h3,
        CMD_LOAD_PC     = 4'h4,
        CMD_LOAD_DP     = 4'h5,
        CMD_CONFIGURE   = 4'h6,
        CMD_UNCONFIGURE = 4'h7,
        CMD_POLL        = 4'h8,
        CMD_RESET       = 4'hF
    } bus_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ
    } state_t;

    localparam int ADDR_NIBBLES = 5;

    function automatic bus_cmd_t read_cmd(input logic is_dp);
        return is_dp ? CMD_DP_READ : CMD_PC_READ;
    endfunction

    function automatic bus_cmd_t load_cmd(input logic is_dp);
        return is_dp ? CMD_LOAD_DP : CMD_LOAD_PC;
    endfunction

endpackage

// File: rtl/saturn_bus_slot_timer.sv
// saturn_bus_slot_timer: free-running bus slot counter with phase-0 flag and early strobe enable
module saturn_bus_slot_timer #(
    parameter int BUS_DIV = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_phase_0,
    output logic o_strobe_next
);

    localparam int CW = $clog2(BUS_DIV);

    logic [CW-1:0] ctr;

    // slot counter wraps 0..BUS_DIV-1 forever, independent of controller state
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            ctr <= '0;
        else
            ctr <= (ctr == CW'(BUS_DIV - 1)) ? '0 : ctr + 1'b1;
    end

    assign o_phase_0     = ctr == '0;
    // one cycle ahead of the strobe slot so the strobe itself can leave a register
    assign o_strobe_next = ctr == CW'(BUS_DIV - 2);

endmodule

// File: rtl/saturn_bus_controller.sv
// saturn_bus_controller: CPU read requests to nibble-serial Saturn bus sequences with PC/DP shadowing
module saturn_bus_controller
    import saturn_bus_controller_pkg::*;
#(
    parameter int BUS_DIV      = 4,
    parameter int MAX_CNT_BITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_req_valid,
    input  logic                    i_req_is_dp,
    input  logic [19:0]             i_req_addr,
    input  logic [MAX_CNT_BITS-1:0] i_req_cnt,
    output logic                    o_req_ready,
    output logic                    o_rd_valid,
    output logic [3:0]              o_rd_nibble,
    output logic                    o_rd_last,
    output logic                    o_bus_clk_en,
    output logic                    o_bus_is_data,
    output logic [3:0]              o_bus_nibble_out,
    input  logic [3:0]              i_bus_nibble_in,
    output logic                    o_phase_0
);

    logic                    strobe_next;
    state_t                  state;
    bus_cmd_t                cmd;
    bus_cmd_t                last_cmd;
    logic                    is_dp;
    logic [19:0]             addr;
    logic [MAX_CNT_BITS-1:0] rem;
    logic [2:0]              idx;
    logic [19:0]             shadow_pc;
    logic [19:0]             shadow_dp;
    logic                    shadow_valid;
    logic                    samp;
    logic                    samp_last;
    logic                    hit;

    saturn_bus_slot_timer #(.BUS_DIV(BUS_DIV)) u_timer (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .o_phase_0     (o_phase_0),
        .o_strobe_next (strobe_next)
    );

    // a request hits when the slave's pointer for that stream already sits at the start address
    always_comb begin
        hit = shadow_valid && (i_req_addr == (i_req_is_dp ? shadow_dp : shadow_pc));
    end

    // request acceptance, bus sequencing, read-data return and pointer shadowing
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= ST_IDLE;
            cmd              <= CMD_RESET;
            last_cmd         <= CMD_RESET;
            is_dp            <= 1'b0;
            addr             <= '0;
            rem              <= '0;
            idx              <= '0;
            shadow_pc        <= '0;
            shadow_dp        <= '0;
            shadow_valid     <= 1'b0;
            samp             <= 1'b0;
            samp_last        <= 1'b0;
            o_req_ready      <= 1'b1;
            o_rd_valid       <= 1'b0;
            o_rd_nibble      <= '0;
            o_rd_last        <= 1'b0;
            o_bus_clk_en     <= 1'b0;
            o_bus_is_data    <= 1'b0;
            o_bus_nibble_out <= '0;
        end else begin
            o_bus_clk_en <= 1'b0;
            samp         <= 1'b0;
            samp_last    <= 1'b0;
            o_rd_valid   <= samp;
            o_rd_last    <= samp_last;
            if (samp)
                o_rd_nibble <= i_bus_nibble_in;
            if (state != ST_IDLE && strobe_next) begin
                o_bus_clk_en     <= 1'b1;
                o_bus_is_data    <= state != ST_CMD;
                o_bus_nibble_out <= (state == ST_CMD) ? cmd :
                                    (state == ST_ADDR) ? 4'(addr >> {idx, 2'b00}) : 4'h0;
            end
            case (state)
                ST_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        is_dp       <= i_req_is_dp;
                        addr        <= i_req_addr;
                        rem         <= i_req_cnt;
                        o_req_ready <= 1'b0;
                        cmd         <= hit ? read_cmd(i_req_is_dp) : load_cmd(i_req_is_dp);
                        state       <= (hit && last_cmd == read_cmd(i_req_is_dp)) ? ST_READ : ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (o_bus_clk_en) begin
                        last_cmd <= cmd;
                        idx      <= '0;
                        state    <= (cmd == CMD_LOAD_PC || cmd == CMD_LOAD_DP) ? ST_ADDR : ST_READ;
                    end
                end
                ST_ADDR: begin
                    if (o_bus_clk_en) begin
                        idx <= idx + 1'b1;
                        // the slave switches itself to the read command after the last address nibble
                        if (idx == 3'(ADDR_NIBBLES - 1)) begin
                            state        <= ST_READ;
                            last_cmd     <= read_cmd(is_dp);
                            shadow_valid <= 1'b1;
                            if (is_dp)
                                shadow_dp <= addr;
                            else
                                shadow_pc <= addr;
                        end
                    end
                end
                ST_READ: begin
                    if (o_bus_clk_en) begin
                        samp      <= 1'b1;
                        samp_last <= rem == '0;
                        rem       <= rem - 1'b1;
                        if (is_dp)
                            shadow_dp <= shadow_dp + 1'b1;
                        else
                            shadow_pc <= shadow_pc + 1'b1;
                        if (rem == '0) begin
                            state       <= ST_IDLE;
                            o_req_ready <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_saturn_bus_controller.sv
// tb_saturn_bus_controller: directed and random read bursts against a slave model and a request-level reference
module tb_saturn_bus_controller;
    import saturn_bus_controller_pkg::*;

    localparam int BUS_DIV = 4;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        i_req_is_dp = 1'b0;
    logic [19:0] i_req_addr = '0;
    logic [3:0]  i_req_cnt = '0;
    logic        o_req_ready, o_rd_valid, o_rd_last, o_bus_clk_en, o_bus_is_data, o_phase_0;
    logic [3:0]  o_rd_nibble, o_bus_nibble_out, i_bus_nibble_in;

    int checks = 0;
    int errors = 0;
    int first_lat;
    int acc_seen;

    logic [4:0] exp_s[$], got_s[$], exp_n[$], got_n[$];

    bit          m_sv;
    logic [19:0] m_sh[2];
    logic [3:0]  m_last;

    logic [19:0] s_ptr[2];
    int          s_mode;
    int          s_cnt;
    logic        s_dp;

    always #5 i_clk = ~i_clk;

    saturn_bus_controller #(.BUS_DIV(BUS_DIV), .MAX_CNT_BITS(4)) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_req_valid      (i_req_valid),
        .i_req_is_dp      (i_req_is_dp),
        .i_req_addr       (i_req_addr),
        .i_req_cnt        (i_req_cnt),
        .o_req_ready      (o_req_ready),
        .o_rd_valid       (o_rd_valid),
        .o_rd_nibble      (o_rd_nibble),
        .o_rd_last        (o_rd_last),
        .o_bus_clk_en     (o_bus_clk_en),
        .o_bus_is_data    (o_bus_is_data),
        .o_bus_nibble_out (o_bus_nibble_out),
        .i_bus_nibble_in  (i_bus_nibble_in),
        .o_phase_0        (o_phase_0)
    );

    function automatic logic [3:0] mem(input logic [19:0] a);
        logic [3:0] m = a[3:0] * 4'd3;
        return m ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ a[19:16];
    endfunction

    // slave: decodes commands, loads pointers LSB first, returns memory on read strobes
    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s_ptr[0]        <= '0;
            s_ptr[1]        <= '0;
            s_mode          <= 0;
            s_cnt           <= 0;
            s_dp            <= 1'b0;
            i_bus_nibble_in <= '0;
        end else if (o_bus_clk_en) begin
            if (!o_bus_is_data) begin
                s_dp   <= (o_bus_nibble_out == CMD_LOAD_DP) || (o_bus_nibble_out == CMD_DP_READ);
                s_mode <= (o_bus_nibble_out == CMD_LOAD_PC || o_bus_nibble_out == CMD_LOAD_DP) ? 1 :
                          (o_bus_nibble_out == CMD_PC_READ || o_bus_nibble_out == CMD_DP_READ) ? 2 : 0;
                s_cnt  <= 0;
            end else if (s_mode == 1) begin
                s_ptr[s_dp][4*s_cnt +: 4] <= o_bus_nibble_out;
                s_cnt <= s_cnt + 1;
                if (s_cnt == 4)
                    s_mode <= 2;
            end else if (s_mode == 2) begin
                i_bus_nibble_in <= mem(s_ptr[s_dp]);
                s_ptr[s_dp]     <= s_ptr[s_dp] + 20'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sv     = 1'b0;
        m_sh[0]  = '0;
        m_sh[1]  = '0;
        m_last   = CMD_RESET;
    endtask

    task automatic model_req(input logic dp, input logic [19:0] a, input logic [3:0] c);
        logic [3:0] rd = dp ? CMD_DP_READ : CMD_PC_READ;
        logic [3:0] ld = dp ? CMD_LOAD_DP : CMD_LOAD_PC;
        if (m_sv && a == m_sh[dp]) begin
            if (m_last != rd)
                exp_s.push_back({1'b0, rd});
        end else begin
            exp_s.push_back({1'b0, ld});
            for (int i = 0; i < 5; i++)
                exp_s.push_back({1'b1, a[4*i +: 4]});
        end
        for (int i = 0; i <= int'(c); i++) begin
            exp_s.push_back(5'h10);
            exp_n.push_back({i == int'(c), mem(a + 20'(i))});
        end
        m_sv     = 1'b1;
        m_last   = rd;
        m_sh[dp] = a + 20'(c) + 20'd1;
    endtask

    task automatic start(input logic dp, input logic [19:0] a, input logic [3:0] c, input bit align, input bit hold);
        int w = 0;
        while ((!o_req_ready || (align && !o_phase_0)) && w < 500) begin
            @(negedge i_clk);
            w++;
        end
        check("ready_wait", o_req_ready, 1);
        model_req(dp, a, c);
        i_req_valid = 1'b1;
        i_req_is_dp = dp;
        i_req_addr  = a;
        i_req_cnt   = c;
        @(posedge i_clk);
        #1;
        if (!hold)
            i_req_valid = 1'b0;
    endtask

    task automatic collect(input int n);
        int cyc = 0;
        first_lat = 0;
        while (got_n.size() < n && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
            if (o_bus_clk_en)
                got_s.push_back({o_bus_is_data, o_bus_nibble_out});
            if (o_rd_valid) begin
                if (got_n.size() == 0)
                    first_lat = cyc;
                got_n.push_back({o_rd_last, o_rd_nibble});
            end
            if (i_req_valid && o_req_ready)
                acc_seen++;
        end
        check("rd_count", got_n.size(), n);
    endtask

    task automatic compare(input string tag);
        check({tag, "_nstrobe"}, got_s.size(), exp_s.size());
        for (int i = 0; i < got_s.size() && i < exp_s.size(); i++)
            check($sformatf("%s_strobe%0d", tag, i), got_s[i], exp_s[i]);
        for (int i = 0; i < got_n.size() && i < exp_n.size(); i++)
            check($sformatf("%s_nib%0d", tag, i), got_n[i], exp_n[i]);
        got_s.delete();
        exp_s.delete();
        got_n.delete();
        exp_n.delete();
    endtask

    task automatic run(input string tag, input logic dp, input logic [19:0] a, input logic [3:0] c);
        start(dp, a, c, 1'b0, 1'b0);
        collect(int'(c) + 1);
        compare(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic       dp;
        logic [3:0] c;
        logic [19:0] a;
        model_reset();
        repeat (3) @(negedge i_clk);
        check("rst_ready", o_req_ready, 1);
        check("rst_rd_valid", o_rd_valid, 0);
        check("rst_rd_last", o_rd_last, 0);
        check("rst_rd_nibble", o_rd_nibble, 0);
        check("rst_clk_en", o_bus_clk_en, 0);
        check("rst_is_data", o_bus_is_data, 0);
        check("rst_nibble_out", o_bus_nibble_out, 0);
        check("rst_phase_0", o_phase_0, 1);
        i_reset_n = 1'b1;

        start(1'b0, 20'h12345, 4'd0, 1'b1, 1'b0);
        collect(1);
        check("miss_latency", first_lat, 7 * BUS_DIV + 1);
        compare("miss");
        run("seq_hit", 1'b0, 20'h12346, 4'd3);
        run("dp_load", 1'b1, 20'h00010, 4'd0);
        run("switch", 1'b0, 20'h1234A, 4'd2);
        run("wrap", 1'b0, 20'hFFFFF, 4'd1);
        run("wrap_hit", 1'b0, 20'h00001, 4'd0);

        acc_seen = 0;
        start(1'b0, 20'h00002, 4'd7, 1'b0, 1'b1);
        collect(8);
        compare("busy1");
        i_req_valid = 1'b0;
        model_req(1'b0, 20'h00002, 4'd7);
        collect(8);
        compare("busy2");
        check("busy_accept_once", acc_seen, 1);

        start(1'b0, m_sh[0], 4'd15, 1'b0, 1'b0);
        collect(3);
        for (int i = 0; i < 3 && i < got_n.size(); i++)
            check($sformatf("abort_nib%0d", i), got_n[i], exp_n[i]);
        got_s.delete();
        exp_s.delete();
        got_n.delete();
        exp_n.delete();
        i_reset_n = 1'b0;
        #1;
        check("abort_ready", o_req_ready, 1);
        check("abort_rd_valid", o_rd_valid, 0);
        check("abort_rd_last", o_rd_last, 0);
        check("abort_rd_nibble", o_rd_nibble, 0);
        check("abort_clk_en", o_bus_clk_en, 0);
        check("abort_is_data", o_bus_is_data, 0);
        check("abort_nibble_out", o_bus_nibble_out, 0);
        model_reset();
        n = 0;
        repeat (4) begin
            @(negedge i_clk);
            n += int'(o_rd_valid);
        end
        check("abort_no_rd", n, 0);
        i_reset_n = 1'b1;
        run("after_reset", 1'b0, 20'h12348, 4'd0);

        for (int k = 0; k < 20; k++) begin
            dp = 1'($urandom_range(0, 1));
            c  = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 1) == 1) ? m_sh[dp] : 20'($urandom);
            run($sformatf("rand%0d", k), dp, a, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
